// File: rtl/gpu_sched_pkg.sv
// Shared types and helpers for the GPU block scheduler: top/core state enums and
// the ceil-divide used to size a kernel launch into thread blocks.
package gpu_sched_pkg;

  typedef enum logic [1:0] {StIdle, StLaunch, StRun, StFinish} top_state_e;
  typedef enum logic [1:0] {CoreFree, CoreRst, CoreBusy} core_state_e;

  // Result is one bit wider than the thread count so ceil() never overflows.
  function automatic logic [32:0] blocks_for(input logic [31:0] threads,
                                             input int unsigned tpb);
    logic [32:0] q;
    q = {1'b0, threads / tpb};
    if ((threads % tpb) != 0) q = q + 33'd1;
    return q;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer upward; the pointer
// moves just past the granted requester whenever advance is asserted.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  logic [PtrW-1:0] r_ptr;
  logic [PtrW-1:0] w_next_ptr;
  logic [PtrW-1:0] w_idx;
  logic [PtrW:0]   w_sum;
  logic            w_found;

  always_comb begin
    grant      = '0;
    w_next_ptr = r_ptr;
    w_found    = 1'b0;
    w_sum      = '0;
    w_idx      = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, r_ptr} + (PtrW+1)'(k);
      if (w_sum >= (PtrW+1)'(N)) w_sum = w_sum - (PtrW+1)'(N);
      w_idx = w_sum[PtrW-1:0];
      if (!w_found && req[w_idx]) begin
        w_found      = 1'b1;
        grant[w_idx] = 1'b1;
        if ({1'b0, w_idx} == (PtrW+1)'(N - 1)) w_next_ptr = '0;
        else                                   w_next_ptr = w_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                   r_ptr <= '0;
    else if (advance && w_found) r_ptr <= w_next_ptr;
  end

endmodule

// File: rtl/block_scheduler.sv
// Kernel block scheduler: splits a launch into thread blocks and dispatches them to
// cores round-robin. BLOCK_SCHEDULER_PERF_EN adds the kernel_cycles RUN-cycle counter.
module block_scheduler
  import gpu_sched_pkg::*;
#(
  parameter int unsigned NUM_CORES         = 2,
  parameter int unsigned THREADS_PER_BLOCK = 4,
  parameter int unsigned TC_W              = 16,
  parameter int unsigned BID_W             = TC_W,
  localparam int unsigned CTW              = $clog2(THREADS_PER_BLOCK) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [TC_W-1:0]            thread_count,
  input  logic [NUM_CORES-1:0]       core_done,
  output logic [NUM_CORES-1:0]       core_start,
  output logic [NUM_CORES-1:0]       core_reset,
  output logic [NUM_CORES*BID_W-1:0] core_block_id,
  output logic [NUM_CORES*CTW-1:0]   core_thread_count,
  output logic                       busy,
  output logic                       done
`ifdef BLOCK_SCHEDULER_PERF_EN
  ,
  output logic [31:0]                kernel_cycles
`endif
);

  localparam logic [TC_W:0]  TpbW = (TC_W+1)'(THREADS_PER_BLOCK);
  localparam logic [CTW-1:0] TpbC = CTW'(THREADS_PER_BLOCK);

  top_state_e                 r_state;
  core_state_e                r_cst [NUM_CORES];
  logic [TC_W-1:0]            r_tc;
  logic [TC_W:0]              r_total, r_next, r_bdone;
  logic [NUM_CORES-1:0]       r_core_start, r_core_reset;
  logic [NUM_CORES*BID_W-1:0] r_core_bid;
  logic [NUM_CORES*CTW-1:0]   r_core_tc;
  logic                       r_busy, r_done;

  logic                 w_abort, w_to_run, w_adv, w_unused_blocks;
  logic [NUM_CORES-1:0] w_req, w_grant, w_fin;
  logic [TC_W:0]        w_ncomp, w_rem;
  logic [CTW-1:0]       w_blk_tc;
  logic [32:0]          w_blocks;

  assign w_blocks        = blocks_for(32'(thread_count), THREADS_PER_BLOCK);
  assign w_unused_blocks = ^w_blocks;
  assign w_abort         = ((r_state == StLaunch) || (r_state == StRun)) && !start;
  assign w_to_run        = (r_state == StLaunch) && start;
  assign w_adv           = |w_grant;
  // Only the final block can have fewer than a full block of threads left.
  assign w_rem    = {1'b0, r_tc} - r_next * TpbW;
  assign w_blk_tc = (w_rem >= TpbW) ? TpbC : w_rem[CTW-1:0];

  always_comb begin
    w_req   = '0;
    w_fin   = '0;
    w_ncomp = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_req[i] = (r_cst[i] == CoreFree) && (r_state == StRun) && start && (r_next < r_total);
      w_fin[i] = (r_cst[i] == CoreBusy) && core_done[i];
      w_ncomp  = w_ncomp + (TC_W+1)'(w_fin[i]);
    end
  end

  rr_arbiter #(
    .N(NUM_CORES)
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (w_req),
    .advance(w_adv),
    .grant  (w_grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_tc         <= '0;
      r_total      <= '0;
      r_next       <= '0;
      r_bdone      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_core_start <= '0;
      r_core_reset <= '0;
      r_core_bid   <= '0;
      r_core_tc    <= {NUM_CORES{TpbC}};
      for (int i = 0; i < NUM_CORES; i++) r_cst[i] <= CoreFree;
    end else begin
      unique case (r_state)
        StIdle: if (start) begin
          r_state <= StLaunch;
          r_busy  <= 1'b1;
        end
        StLaunch: if (start) begin
          r_tc    <= thread_count;
          r_total <= w_blocks[TC_W:0];
          r_next  <= '0;
          r_bdone <= '0;
          r_state <= StRun;
        end
        StRun: if (start) begin
          if (r_bdone == r_total) begin
            r_state <= StFinish;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
          r_bdone <= r_bdone + w_ncomp;
          if (w_adv) r_next <= r_next + 1'b1;
        end
        StFinish: if (!start) begin
          r_state <= StIdle;
          r_done  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
      if (w_abort) begin
        r_state <= StIdle;
        r_busy  <= 1'b0;
        r_total <= '0;
        r_next  <= '0;
        r_bdone <= '0;
      end
      // Abort and run entry both park every core in reset for one cycle.
      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_abort || w_to_run) begin
          r_cst[i]        <= CoreRst;
          r_core_reset[i] <= 1'b1;
          r_core_start[i] <= 1'b0;
        end else begin
          unique case (r_cst[i])
            CoreRst: begin
              r_cst[i]        <= CoreFree;
              r_core_reset[i] <= 1'b0;
            end
            CoreFree: if (w_grant[i]) begin
              r_cst[i]                      <= CoreBusy;
              r_core_start[i]               <= 1'b1;
              r_core_bid[i*BID_W +: BID_W]  <= BID_W'(r_next);
              r_core_tc[i*CTW +: CTW]       <= w_blk_tc;
            end
            CoreBusy: if (core_done[i]) begin
              r_cst[i]        <= CoreRst;
              r_core_start[i] <= 1'b0;
              r_core_reset[i] <= 1'b1;
            end
            default: r_cst[i] <= CoreFree;
          endcase
        end
      end
    end
  end

  assign core_start        = r_core_start;
  assign core_reset        = r_core_reset;
  assign core_block_id     = r_core_bid;
  assign core_thread_count = r_core_tc;
  assign busy              = r_busy;
  assign done              = r_done;

`ifdef BLOCK_SCHEDULER_PERF_EN
  logic [31:0] r_kcyc;

  always_ff @(posedge clk) begin
    if (reset)                                  r_kcyc <= '0;
    else if (r_state == StLaunch)               r_kcyc <= '0;
    else if (r_state == StRun && r_kcyc != '1)  r_kcyc <= r_kcyc + 32'd1;
  end

  assign kernel_cycles = r_kcyc;
`endif

endmodule

// File: tb/tb_block_scheduler.sv
// Directed bench for block_scheduler: a dispatch scoreboard fed at kernel start and
// drained as core_start rises, plus a 4-core instance for round-robin ordering.
module tb_block_scheduler;

  localparam int NC = 2;
  localparam int BW = 16;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [15:0]   thread_count;
  logic [NC-1:0] core_done, core_start, core_reset;
  logic [NC*BW-1:0] core_block_id;
  logic [NC*CW-1:0] core_thread_count;
  logic          busy, done;

  logic        start4;
  logic [15:0] tc4;
  logic [3:0]  core_done4, core_start4, core_reset4;
  logic [63:0] core_block_id4;
  logic [11:0] core_thread_count4;
  logic        busy4, done4;
`ifdef BLOCK_SCHEDULER_PERF_EN
  logic [31:0] kernel_cycles, kernel_cycles4;
`endif

  always #5 clk = ~clk;

  block_scheduler dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .thread_count     (thread_count),
    .core_done        (core_done),
    .core_start       (core_start),
    .core_reset       (core_reset),
    .core_block_id    (core_block_id),
    .core_thread_count(core_thread_count),
    .busy             (busy),
    .done             (done)
`ifdef BLOCK_SCHEDULER_PERF_EN
    ,
    .kernel_cycles    (kernel_cycles)
`endif
  );

  block_scheduler #(
    .NUM_CORES(4)
  ) dut4 (
    .clk              (clk),
    .reset            (reset),
    .start            (start4),
    .thread_count     (tc4),
    .core_done        (core_done4),
    .core_start       (core_start4),
    .core_reset       (core_reset4),
    .core_block_id    (core_block_id4),
    .core_thread_count(core_thread_count4),
    .busy             (busy4),
    .done             (done4)
`ifdef BLOCK_SCHEDULER_PERF_EN
    ,
    .kernel_cycles    (kernel_cycles4)
`endif
  );

  int total = 0;
  int bad = 0;
  int rsp_delay = 3;

  typedef struct {
    int core;
    int id;
    int tc;
  } disp_t;
  disp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int c, input int id, input int tc);
    sb.push_back('{core: c, id: id, tc: tc});
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int lim);
    int k = 0;
    while (done !== 1'b1 && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done_seen"}, 64'(done === 1'b1), 64'd1);
  endtask

  task automatic wait_start(input string tag, input logic [NC-1:0] want, input int lim);
    int k = 0;
    while (core_start !== want && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_start_seen"}, 64'(core_start), 64'(want));
  endtask

  // Core model: raise core_done for one cycle rsp_delay cycles after core_start rises.
  initial begin
    int cnt [NC];
    logic [NC-1:0] prev;
    core_done = '0;
    prev = '0;
    for (int i = 0; i < NC; i++) cnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NC; i++) begin
        core_done[i] = 1'b0;
        if (core_start[i] !== 1'b1) cnt[i] = 0;
        else if (!prev[i]) cnt[i] = rsp_delay;
        else if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) core_done[i] = 1'b1;
        end
      end
      prev = core_start;
    end
  end

  // Scoreboard drain on each dispatch.
  initial begin
    logic [NC-1:0] prev;
    disp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NC; i++) begin
        if (core_start[i] === 1'b1 && !prev[i]) begin
          if (sb.size() == 0) begin
            chk($sformatf("spurious_dispatch_core%0d", i), 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            chk("disp_core", 64'(i), 64'(e.core));
            chk("disp_id", 64'(core_block_id[i*BW +: BW]), 64'(e.id));
            chk("disp_tc", 64'(core_thread_count[i*CW +: CW]), 64'(e.tc));
          end
        end
      end
      prev = core_start;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int nb;
    reset = 1'b1; start = 1'b0; thread_count = '0;
    start4 = 1'b0; tc4 = '0; core_done4 = '0;
    step(3);
    chk("rst_core_start", 64'(core_start), 64'd0);
    chk("rst_core_reset", 64'(core_reset), 64'd0);
    chk("rst_block_id", 64'(core_block_id), 64'd0);
    chk("rst_thread_cnt", 64'(core_thread_count), 64'o44);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
`ifdef BLOCK_SCHEDULER_PERF_EN
    chk("rst_kcycles", 64'(kernel_cycles), 64'd0);
`endif
    reset = 1'b0;
    step(1);

    // 8 threads: two full blocks on cores 0 and 1.
    thread_count = 16'd8; start = 1'b1;
    push(0, 0, 4); push(1, 1, 4);
    wait_done("a", 60);
    chk("a_busy", 64'(busy), 64'd0);
    chk("a_sb_empty", 64'(sb.size()), 64'd0);
    step(2);
    chk("a_done_hold", 64'(done), 64'd1);
    start = 1'b0;
    step(1);
    chk("a_done_clear", 64'(done), 64'd0);

    // 10 threads: partial final block of 2 on the first core to free up.
    thread_count = 16'd10; start = 1'b1;
    push(0, 0, 4); push(1, 1, 4); push(0, 2, 2);
    wait_done("b", 80);
    chk("b_sb_empty", 64'(sb.size()), 64'd0);
    start = 1'b0;
    step(1);

    // Empty kernel: straight to FINISH, nothing dispatched.
    thread_count = 16'd0; start = 1'b1;
    step(1);
    chk("c_busy_launch", 64'(busy), 64'd1);
    step(2);
    chk("c_done_3cyc", 64'(done), 64'd1);
    start = 1'b0;
    step(1);
    chk("c_done_clear", 64'(done), 64'd0);

    // Abort with both cores busy; pointer now favours core 1.
    rsp_delay = 20;
    thread_count = 16'd8; start = 1'b1;
    push(1, 0, 4); push(0, 1, 4);
    wait_start("d", 2'b11, 20);
    start = 1'b0;
    step(1);
    chk("d_abort_reset", 64'(core_reset), 64'd3);
    chk("d_abort_start", 64'(core_start), 64'd0);
    chk("d_abort_busy", 64'(busy), 64'd0);
    step(1);
    chk("d_reset_pulse", 64'(core_reset), 64'd0);
    chk("d_sb_empty", 64'(sb.size()), 64'd0);
    rsp_delay = 3;
    start = 1'b1;
    push(1, 0, 4); push(0, 1, 4);
    wait_done("d2", 60);
    chk("d2_sb_empty", 64'(sb.size()), 64'd0);
    start = 1'b0;
    step(1);

    // Reset mid-RUN wins over a held start.
    start = 1'b1;
    push(1, 0, 4);
    wait_start("e", 2'b10, 20);
    reset = 1'b1;
    step(2);
    chk("e_rst_start", 64'(core_start), 64'd0);
    chk("e_rst_reset", 64'(core_reset), 64'd0);
    chk("e_rst_busy", 64'(busy), 64'd0);
    chk("e_rst_bid", 64'(core_block_id), 64'd0);
    chk("e_rst_tc", 64'(core_thread_count), 64'o44);
    start = 1'b0; reset = 1'b0;
    step(1);

    // Four cores eligible together: one grant per cycle in order 0..3.
    tc4 = 16'd16; start4 = 1'b1;
    k = 0;
    while (core_start4 === 4'b0000 && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("f_grant0", 64'(core_start4), 64'h1);
    step(1);
    chk("f_grant1", 64'(core_start4), 64'h3);
    step(1);
    chk("f_grant2", 64'(core_start4), 64'h7);
    step(1);
    chk("f_grant3", 64'(core_start4), 64'hf);
    chk("f_ids", core_block_id4, 64'h0003_0002_0001_0000);
    start4 = 1'b0;
    step(2);
    chk("f_abort", 64'(core_start4), 64'd0);

    // Single block, 5-cycle core: RUN length measured from busy.
    rsp_delay = 5;
    thread_count = 16'd4; start = 1'b1;
    push(0, 0, 4);
    k = 0; nb = 0;
    while (done !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
      if (busy === 1'b1) nb++;
    end
    chk("g_done_seen", 64'(done === 1'b1), 64'd1);
    chk("g_busy_cycles", 64'(nb), 64'd10);
`ifdef BLOCK_SCHEDULER_PERF_EN
    chk("g_kcycles", 64'(kernel_cycles), 64'(nb - 1));
    step(3);
    chk("g_kcycles_frozen", 64'(kernel_cycles), 64'(nb - 1));
`endif
    start = 1'b0;
    step(2);
`ifdef BLOCK_SCHEDULER_PERF_EN
    chk("g_kcycles_idle", 64'(kernel_cycles), 64'(nb - 1));
`endif
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/block_scheduler.md
BLOCK_SCHEDULER -- requirements
Module: block_scheduler

Interface
REQ-001 SHALL have parameter NUM_CORES, default 2, number of compute cores served.
REQ-002 SHALL have parameter THREADS_PER_BLOCK, default 4, power of two, ≥1.
REQ-003 SHALL have parameter TC_W, default 16, width of the kernel thread count.
REQ-004 SHALL have parameter BID_W, default TC_W, width of a block id.
REQ-005 SHALL have ports: clk  in  1  clock; reset  in  1  synchronous active-high reset.
REQ-006 SHALL have ports: start  in  1  level, kernel run request; thread_count  in  TC_W  total threads, sampled on launch.
REQ-007 SHALL have ports: core_done  in  NUM_CORES  per-core block complete; core_start  out  NUM_CORES; core_reset  out  NUM_CORES.
REQ-008 SHALL have ports: core_block_id  out  NUM_CORES*BID_W, packed with core i at bits [i*BID_W +: BID_W]; core_thread_count  out  NUM_CORES*(clog2(THREADS_PER_BLOCK)+1), packed the same way.
REQ-009 SHALL have ports: busy  out  1; done  out  1.

Function
REQ-010 SHALL run a top FSM with states IDLE, LAUNCH, RUN, FINISH.
REQ-011 IDLE→LAUNCH when start=1; in LAUNCH, SHALL latch thread_count and compute total_blocks = ceil(thread_count/THREADS_PER_BLOCK) at TC_W+1 bits with no overflow, then go to RUN on the next cycle.
REQ-012 SHALL give each core its own FSM with states C_FREE, C_RST, C_BUSY; entering RUN, all cores go to C_RST.
REQ-013 core_reset[i] SHALL be 1 for exactly one cycle per C_RST visit; the next cycle, the core is eligible for a block.
REQ-014 SHALL dispatch at most one block per cycle, granted round-robin among eligible cores, with the pointer starting at core 0 after reset and advancing past the granted core.
REQ-015 On a grant, core_start[i]=1, core_block_id[i]=next block id, and core_thread_count[i]=THREADS_PER_BLOCK, except for the final block, which gets thread_count − id*THREADS_PER_BLOCK; the core then goes to C_BUSY.
REQ-016 core_start[i] SHALL hold high until the cycle after core_done[i] is sampled high in C_BUSY; the core then goes to C_RST and blocks_done increments.
REQ-017 core_done[i] SHALL be ignored when core i is not in C_BUSY.
REQ-018 A same-cycle grant and any number of completions SHALL all be counted, with no lost increment.
REQ-019 An eligible core with no blocks remaining SHALL go to C_FREE, with core_start low.
REQ-020 RUN→FINISH when blocks_done==total_blocks; thread_count=0 SHALL reach FINISH with zero dispatches.
REQ-021 In FINISH, done=1 SHALL hold while start=1; start=0 SHALL return to IDLE and clear done.
REQ-022 start deasserted during LAUNCH or RUN SHALL abort: for one cycle, every core gets core_reset=1 and core_start=0, then the FSM goes to IDLE with counters cleared.
REQ-023 busy SHALL be 1 in LAUNCH and RUN.

Reset
REQ-024 reset SHALL override all inputs, including start.
REQ-025 On reset: FSM=IDLE; all core FSMs=C_FREE; all counters and the RR pointer=0.
REQ-026 On reset: core_start=0, core_reset=0, core_block_id=0, core_thread_count=THREADS_PER_BLOCK, busy=0, done=0.
REQ-027 Reset mid-RUN SHALL take effect in the same cycle, with no completions counted.

Configuration
REQ-028 Macro BLOCK_SCHEDULER_PERF_EN defined SHALL add output kernel_cycles (32 bits), cleared in LAUNCH, incremented each RUN cycle, held in FINISH/IDLE, saturating at all-ones, reset value 0.
REQ-029 Macro undefined SHALL remove the port and its logic entirely; all other behaviour identical.

Structure
REQ-030 Package gpu_sched_pkg SHALL hold the top-state and core-state enums and a function blocks_for(threads, tpb).
REQ-031 Sub-module rr_arbiter (parameter N; ports req, grant one-hot, advance) SHALL implement the round-robin grant of REQ-014.

Verification
REQ-032 NUM_CORES=2, TPB=4, thread_count=8, each core answering done 3 cycles after start -> ids 0 and 1, then 1 on core 1; counts 4,4; done after 2 blocks; zero dispatches after the second.
REQ-033 thread_count=10, TPB=4 -> three blocks, thread counts 4,4,2; final block id 2.
REQ-034 thread_count=0 -> no core_start, done=1 within 3 cycles of start.
REQ-035 NUM_CORES=4, all cores eligible together -> grants to cores 0,1,2,3 on consecutive cycles, one per cycle.
REQ-036 start dropped mid-RUN with 2 cores busy -> one-cycle core_reset=11, core_start=00, then IDLE; a new start re-dispatches from block 0.
REQ-037 PERF_EN, thread_count=4, core done 5 cycles after start -> kernel_cycles equals the measured RUN cycle count, frozen after done.
